// File: rtl/as_load_scoreboard.sv
// Load-use hazard unit: tracks in-flight loads for LOAD_LAT cycles and stalls decode
// while a consumed source register still waits on load data. Also counts stall cycles.
module as_load_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32,
    parameter int X0_ZERO  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_rd_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              flush_i,
    output logic              stall_n_o,
    output logic              bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              load_ex;
    logic              hazard;
    logic              hazard_q;
    logic              rs1_ok;
    logic              rs2_ok;
    logic [CNT_W-1:0]  stall_cnt_reg;

    // Pending set indexed by age: age 0 is the load currently in execute.
    logic [LOAD_LAT-1:0] pend_v;
    logic [REG_AW-1:0]   pend_rd [LOAD_LAT];
    logic [LOAD_LAT-1:0] rs1_match;
    logic [LOAD_LAT-1:0] rs2_match;

    assign load_ex    = ex_valid_i & ex_mem_rd_i & ((ex_rd_i != '0) | (X0_ZERO == 0));
    assign pend_v[0]  = load_ex;
    assign pend_rd[0] = ex_rd_i;

    generate
        for (genvar gi = 1; gi < LOAD_LAT; gi++) begin : g_pipe
            logic              v_reg;
            logic [REG_AW-1:0] rd_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v_reg  <= 1'b0;
                    rd_reg <= '0;
                end else begin
                    v_reg  <= pend_v[gi-1];
                    rd_reg <= pend_rd[gi-1];
                end
            end

            assign pend_v[gi]  = v_reg;
            assign pend_rd[gi] = rd_reg;
        end

        for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : g_match
            assign rs1_match[gi] = pend_v[gi] & (pend_rd[gi] == id_rs1_i);
            assign rs2_match[gi] = pend_v[gi] & (pend_rd[gi] == id_rs2_i);
        end
    endgenerate

    // x0 never waits on a load when it is hardwired to zero.
    assign rs1_ok = (id_rs1_i != '0) | (X0_ZERO == 0);
    assign rs2_ok = (id_rs2_i != '0) | (X0_ZERO == 0);

    assign hazard = id_valid_i & ~flush_i &
                    ((id_rs1_used_i & rs1_ok & (|rs1_match)) |
                     (id_rs2_used_i & rs2_ok & (|rs2_match)));

    assign hazard_q  = hazard & ~rst_i;
    assign stall_n_o = ~hazard_q;
    assign bubble_o  = hazard_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (hazard_q && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_as_load_scoreboard.sv
// Bench for as_load_scoreboard: four parameterisations share one stimulus stream and are
// compared each cycle against a per-register "cycle of last load" reference model.
module tb_as_load_scoreboard;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs1_i = '0;
    logic [4:0] id_rs2_i = '0;
    logic       id_rs1_used_i = 1'b0;
    logic       id_rs2_used_i = 1'b0;
    logic       ex_valid_i = 1'b0;
    logic       ex_mem_rd_i = 1'b0;
    logic [4:0] ex_rd_i = '0;
    logic       flush_i = 1'b0;

    logic [3:0]  sn, bb;
    logic [31:0] cnt1, cnt2, cnt3;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    as_load_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32), .X0_ZERO(1)) u_l1 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_valid_i(ex_valid_i), .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .stall_n_o(sn[0]), .bubble_o(bb[0]), .stall_cnt_o(cnt1));

    as_load_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(32), .X0_ZERO(1)) u_l2 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_valid_i(ex_valid_i), .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .stall_n_o(sn[1]), .bubble_o(bb[1]), .stall_cnt_o(cnt2));

    as_load_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32), .X0_ZERO(0)) u_l3 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_valid_i(ex_valid_i), .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .stall_n_o(sn[2]), .bubble_o(bb[2]), .stall_cnt_o(cnt3));

    as_load_scoreboard #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(4), .X0_ZERO(1)) u_l4 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_valid_i(ex_valid_i), .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .stall_n_o(sn[3]), .bubble_o(bb[3]), .stall_cnt_o(cnt4));

    // Reference model: cycle number at which each register last had a load in execute.
    int     lat_p [4] = '{1, 2, 3, 4};
    bit     x0z_p [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    longint max_p [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    longint exp_cnt [4];
    int     last_load [32];
    int     cyc = 0;
    bit     exp_haz [4];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit hit(input int rs, input int lat, input bit x0z);
        if (x0z && rs == 0) return 1'b0;
        if (ex_valid_i && ex_mem_rd_i && int'(ex_rd_i) == rs) return 1'b1;
        return (cyc - last_load[rs]) < lat;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) last_load[r] = -1000;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        longint cnt_obs [4];
        #1;
        cnt_obs = '{longint'(cnt1), longint'(cnt2), longint'(cnt3), longint'(cnt4)};
        for (int i = 0; i < 4; i++) begin
            exp_haz[i] = !rst_i && id_valid_i && !flush_i &&
                         ((id_rs1_used_i && hit(int'(id_rs1_i), lat_p[i], x0z_p[i])) ||
                          (id_rs2_used_i && hit(int'(id_rs2_i), lat_p[i], x0z_p[i])));
            check($sformatf("stall_n_l%0d", i + 1), longint'(sn[i]), longint'(!exp_haz[i]));
            check($sformatf("bubble_l%0d", i + 1), longint'(bb[i]), longint'(exp_haz[i]));
            check($sformatf("cnt_l%0d", i + 1), cnt_obs[i], exp_cnt[i]);
        end
        $display("cyc %0d rst %b id v%b rs1 %0d/%b rs2 %0d/%b ex v%b ld%b rd %0d fl %b stall_n %b%b%b%b cnt %0d %0d %0d %0d",
                 cyc, rst_i, id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
                 ex_valid_i, ex_mem_rd_i, ex_rd_i, flush_i, sn[0], sn[1], sn[2], sn[3],
                 cnt1, cnt2, cnt3, cnt4);
        @(posedge clk);
        if (rst_i) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++)
                if (exp_haz[i] && exp_cnt[i] < max_p[i]) exp_cnt[i]++;
            if (ex_valid_i && ex_mem_rd_i) last_load[ex_rd_i] = cyc;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit iv, input int rs1, input bit u1,
                         input int rs2, input bit u2, input bit ev, input bit ld,
                         input int rd, input bit fl);
        rst_i = r; id_valid_i = iv; id_rs1_i = 5'(rs1); id_rs1_used_i = u1;
        id_rs2_i = 5'(rs2); id_rs2_used_i = u2; ex_valid_i = ev; ex_mem_rd_i = ld;
        ex_rd_i = 5'(rd); flush_i = fl;
        step();
    endtask

    initial begin
        model_reset();
        // Bring every instance out of the unknown power-up state before checking.
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Reset cycle, then a load x5 with a dependent consumer behind it.
        drive(1, 1, 5, 1, 0, 0, 1, 1, 5, 0);
        drive(0, 1, 5, 1, 0, 0, 1, 1, 5, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        // rs2 load-use, unused rs2, invalid decode, flush, x0 cases.
        drive(0, 1, 1, 0, 7, 1, 1, 1, 7, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 7, 1, 0, 0, 0, 0);
        drive(0, 1, 9, 0, 9, 0, 1, 1, 9, 0);
        drive(0, 0, 9, 1, 9, 1, 1, 1, 9, 0);
        drive(0, 1, 9, 1, 9, 1, 1, 1, 9, 1);
        drive(0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 1, 1, 1, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        // Reset in the middle of a stall.
        drive(0, 1, 3, 1, 0, 0, 1, 1, 3, 0);
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        // Continuous stalls to drive the 4-bit counter into saturation.
        for (int k = 0; k < 22; k++) drive(0, 1, 5, 1, 0, 0, 1, 1, 5, 0);
        // Randomised traffic over a small register window to provoke many hits.
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
